// File: rtl/jk_ctrl_pkg.sv
// ============================================================================
// Module      : jk_ctrl_pkg
// Description : Shared encodings for the JK bank controller: command opcodes,
//               FSM state enum and opcode-to-J/K decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jk_ctrl_pkg;

    localparam logic [1:0] C_OP_HOLD   = 2'b00;
    localparam logic [1:0] C_OP_RESET  = 2'b01;
    localparam logic [1:0] C_OP_SET    = 2'b10;
    localparam logic [1:0] C_OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_APPLY = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic op_drives_j(input logic [1:0] op);
        return (op == C_OP_SET) || (op == C_OP_TOGGLE);
    endfunction

    function automatic logic op_drives_k(input logic [1:0] op);
        return (op == C_OP_RESET) || (op == C_OP_TOGGLE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/jk_bank_model.sv
// ============================================================================
// Module      : jk_bank_model
// Description : Expected-state model of the JK bank with a sticky mismatch
//               flag. Only compiled when JK_BANK_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef JK_BANK_CHECK_EN
module jk_bank_model #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_init,
    input  logic             i_apply,
    input  logic [WIDTH-1:0] i_j,
    input  logic [WIDTH-1:0] i_k,
    input  logic [WIDTH-1:0] i_q,
    output logic             o_err
);

    logic [WIDTH-1:0] r_exp;
    logic             r_err;

    // Mirrors the JK characteristic equation, one application per APPLY edge.
    always_ff @(posedge clk) begin
        if (rst || i_init) begin
            r_exp <= '0;
        end else if (i_apply) begin
            r_exp <= (i_j & ~r_exp) | (~i_k & r_exp);
        end
    end

    // The bank contents are undefined until the INIT edge clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (!i_init && (i_q != r_exp)) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;

endmodule
`endif

`default_nettype wire

// File: rtl/jk_bank_ctrl.sv
// ============================================================================
// Module      : jk_bank_ctrl
// Description : Command sequencer driving J/K vectors into an external bank of
//               JK flip-flops. Optional bank checker under JK_BANK_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_bank_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_rep,
    input  logic             abort,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    input  logic [WIDTH-1:0] q_in,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             w_accept;
    logic             w_last;

    assign w_accept = cmd_valid && (r_state == ST_IDLE);
    assign w_last   = (r_state == ST_APPLY) && ((r_cnt == '0) || abort);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:  w_next = ST_IDLE;
            ST_IDLE:  if (w_accept) w_next = ST_APPLY;
            ST_APPLY: if (w_last) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_INIT;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // K resets to all ones so the unreset bank is cleared while rst is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_j   <= '0;
            r_k   <= '1;
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_j <= '0;
                    r_k <= '0;
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        r_j   <= cmd_mask & {WIDTH{op_drives_j(cmd_op)}};
                        r_k   <= cmd_mask & {WIDTH{op_drives_k(cmd_op)}};
                        r_cnt <= cmd_rep;
                    end
                end
                ST_APPLY: begin
                    if (w_last) begin
                        r_j <= '0;
                        r_k <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign j_out = r_j;
    assign k_out = r_k;

`ifdef JK_BANK_CHECK_EN
    jk_bank_model #(
        .WIDTH (WIDTH)
    ) u_model (
        .clk     (clk),
        .rst     (rst),
        .i_init  (r_state == ST_INIT),
        .i_apply (r_state == ST_APPLY),
        .i_j     (r_j),
        .i_k     (r_k),
        .i_q     (q_in),
        .o_err   (err)
    );
`else
    logic w_unused_q;
    assign w_unused_q = ^q_in;
    assign err        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jk_bank_ctrl.sv
// ============================================================================
// Module      : tb_jk_bank_ctrl
// Description : Directed self-checking bench for jk_bank_ctrl with a
//               behavioural JK flip-flop bank on j_out/k_out/q_in.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_bank_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;
`ifdef JK_BANK_CHECK_EN
    localparam logic C_CHK = 1'b1;
`else
    localparam logic C_CHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [CNT_W-1:0] cmd_rep;
    logic             abort;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic [WIDTH-1:0] q_in;
    logic             busy;
    logic             done;
    logic             err;

    logic [WIDTH-1:0] r_bank = 4'b1011;
    logic [WIDTH-1:0] r_flip = 4'b0000;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    jk_bank_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mask  (cmd_mask),
        .cmd_rep   (cmd_rep),
        .abort     (abort),
        .j_out     (j_out),
        .k_out     (k_out),
        .q_in      (q_in),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Behavioural bank: plain JK flip-flops without reset.
    always @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            case ({j_out[i], k_out[i]})
                2'b01:   r_bank[i] <= 1'b0;
                2'b10:   r_bank[i] <= 1'b1;
                2'b11:   r_bank[i] <= ~r_bank[i];
                default: r_bank[i] <= r_bank[i];
            endcase
        end
    end

    assign q_in = r_bank ^ r_flip;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command in IDLE; returns #1 after the accept edge.
    task automatic send(input logic [1:0] op, input logic [3:0] mask, input logic [3:0] rep);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = mask;
        cmd_rep   = rep;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_mask  = 4'b0000;
        cmd_rep   = 4'd0;
        abort     = 1'b0;

        // Reset release
        tick();
        tick();
        check_val("rst_k", k_out, 4'b1111);
        check_val("rst_j", j_out, 4'b0000);
        check_val("rst_ready", cmd_ready, 1'b0);
        check_val("rst_busy", busy, 1'b1);
        check_val("rst_done", done, 1'b0);
        check_val("rst_err", err, 1'b0);
        rst = 1'b0;
        check_val("init_k", k_out, 4'b1111);
        tick();
        check_val("idle_q", q_in, 4'b0000);
        check_val("idle_ready", cmd_ready, 1'b1);
        check_val("idle_busy", busy, 1'b0);
        check_val("idle_k", k_out, 4'b0000);

        // SET mask 0101 rep 0
        send(2'b10, 4'b0101, 4'd0);
        check_val("set_j", j_out, 4'b0101);
        check_val("set_k", k_out, 4'b0000);
        check_val("set_ready", cmd_ready, 1'b0);
        tick();
        check_val("set_q", q_in, 4'b0101);
        check_val("set_done", done, 1'b1);
        tick();
        check_val("set_done_clr", done, 1'b0);
        check_val("set_ready_back", cmd_ready, 1'b1);

        // TOGGLE mask 1111 rep 2
        send(2'b11, 4'b1111, 4'd2);
        tick();
        check_val("tog_q1", q_in, 4'b1010);
        check_val("tog_done1", done, 1'b0);
        tick();
        check_val("tog_q2", q_in, 4'b0101);
        check_val("tog_done2", done, 1'b0);
        tick();
        check_val("tog_q3", q_in, 4'b1010);
        check_val("tog_done3", done, 1'b1);
        tick();
        check_val("tog_idle", cmd_ready, 1'b1);

        // Abort: TOGGLE mask 0001 rep 7, abort before E2
        send(2'b11, 4'b0001, 4'd7);
        tick();
        check_val("abt_q1", q_in, 4'b1011);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abt_q2", q_in, 4'b1010);
        check_val("abt_done", done, 1'b1);
        check_val("abt_j", j_out, 4'b0000);
        tick();
        check_val("abt_q_after", q_in, 4'b1010);
        check_val("abt_ready", cmd_ready, 1'b1);

        // RESET then HOLD
        send(2'b10, 4'b1111, 4'd0);
        tick();
        check_val("pre_q", q_in, 4'b1111);
        tick();
        send(2'b01, 4'b0011, 4'd0);
        check_val("rs_k", k_out, 4'b0011);
        tick();
        check_val("rs_q", q_in, 4'b1100);
        check_val("rs_done", done, 1'b1);
        tick();
        send(2'b00, 4'b1111, 4'd3);
        check_val("hold_jk", {j_out, k_out}, 8'h00);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_val("hold_q", q_in, 4'b1100);
            check_val("hold_done", done, (i == 4) ? 1'b1 : 1'b0);
        end
        tick();
        check_val("hold_ready", cmd_ready, 1'b1);

        // Reset mid-command re-clears the bank
        send(2'b11, 4'b0011, 4'd9);
        tick();
        check_val("mid_q1", q_in, 4'b1111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_k", k_out, 4'b1111);
        check_val("mid_busy", busy, 1'b1);
        check_val("mid_done", done, 1'b0);
        tick();
        check_val("mid_q_clr", q_in, 4'b0000);
        check_val("mid_ready", cmd_ready, 1'b1);

        // Checker: corrupt q_in bit2 for one IDLE cycle
        check_val("chk_err_pre", err, 1'b0);
        r_flip = 4'b0100;
        tick();
        r_flip = 4'b0000;
        check_val("chk_err_set", err, C_CHK);
        tick();
        tick();
        check_val("chk_err_sticky", err, C_CHK);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("chk_err_rst", err, 1'b0);
        tick();
        tick();
        check_val("chk_err_clean", err, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/jk_bank_ctrl.md
# jk_bank_ctrl

Command-driven sequencer for a bank of `WIDTH` external `jk_ff` instances. It accepts one command at a time over a valid/ready handshake: operation, bit mask and repeat count. It then drives registered J/K vectors into the bank for the requested number of clock edges and signals completion. After reset it first forces the bank to a known all-zero state, because the flip-flops themselves have no reset. It sits between a test/control master and the flip-flop bank, and is the only driver of the bank's J and K pins.

## Interface
- `WIDTH`, 4: number of JK flip-flops in the bank.
- `CNT_W`, 4: width of the repeat-count field.
- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  2  operation: 00 HOLD (J=0,K=0), 01 RESET (J=0,K=1), 10 SET (J=1,K=0), 11 TOGGLE (J=1,K=1).
- `cmd_mask`  in  WIDTH  bits affected; unmasked bits get J=K=0.
- `cmd_rep`  in  CNT_W  repeat field; applications = `cmd_rep`+1.
- `abort`  in  1  terminate the running command early.
- `j_out`  out  WIDTH  registered J vector to the bank.
- `k_out`  out  WIDTH  registered K vector to the bank.
- `q_in`  in  WIDTH  bank Q outputs.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky bank-mismatch flag (see Configuration).

## Operation
- States: INIT, IDLE, APPLY, DONE. `rst` forces INIT.
- **Reset values:**
  - `j_out`=0, `k_out`=all ones, so the bank clears on the first edge after reset.
  - `cmd_ready`=0, `busy`=1, `done`=0, `err`=0.
  - repeat counter=0, expected-state register=0.
- **INIT:** held for exactly one cycle; next state IDLE. On that transition `j_out`←0 and `k_out`←0.
- **IDLE:** `cmd_ready`=1. A handshake (`cmd_valid` && `cmd_ready`) loads the following at the same edge, then state goes to APPLY:
  - `j_out`←`mask & {WIDTH{op[1]}}`, `k_out`←`mask & {WIDTH{op[0]}}`;
  - counter←`cmd_rep`.
- **APPLY:** each posedge is one application to the bank.
  - If counter==0 or `abort`=1, the current edge still applies; then state←DONE and `j_out`/`k_out`←0.
  - Otherwise counter decrements and J/K are held.
- **DONE:** `done`=1 for one cycle, then IDLE.
- Commands offered outside IDLE are not accepted; `cmd_valid` may stay high.
- `abort` is ignored outside APPLY.
- HOLD still consumes `cmd_rep`+1 cycles and pulses `done`.
- `rst` asserted mid-command discards the command and re-enters INIT; the bank is re-cleared.

## Timing
- Accept edge E0. Applications occur at edges E1 … E(rep+1). `done` is high in the cycle after E(rep+1).
- Latency from accept edge to `done` high: `cmd_rep`+1 cycles. The next command can be accepted `cmd_rep`+3 edges after E0.
- Abort sampled at APPLY edge Ek leaves exactly k applications.
- `q_in` is expected to reflect an application one cycle after its edge, since the bank and the controller share `clk`.

## Configuration
- `JK_BANK_CHECK_EN` defined:
  - An internal model tracks the expected bank state. At each APPLY edge, exp←`(j_out & ~exp) | (~k_out & exp)`. At the INIT edge, exp←0.
  - In every cycle except INIT, `q_in`≠exp sets `err`. `err` stays set until `rst`.
- Not defined: no model, no compare logic; `err` is tied to 0.

## Structure
- Package `jk_ctrl_pkg`: op encodings (HOLD/RESET/SET/TOGGLE) and the state enum (INIT/IDLE/APPLY/DONE).
- Sub-module `jk_bank_model` holds the expected-state register and the compare. It is instantiated only under `JK_BANK_CHECK_EN`.
- Top-level owns the FSM, the counter and the J/K registers.

## Test plan
All scenarios use WIDTH=4 and the real `jk_ff` bank.
- **Reset release:** `rst` high 2 cycles, then low → `k_out`=1111 for one cycle, then `q_in`=0000, `cmd_ready`=1 and `busy`=0 from the second cycle.
- **SET:** mask 0101, rep 0 → `q_in`=0101 one cycle after E1; `done` high exactly one cycle after E1; `cmd_ready` back next cycle.
- **TOGGLE:** mask 1111, rep 2, starting from 0101 → `q_in` sequence 1010, 0101, 1010; `done` high one cycle after E3.
- **Abort:** TOGGLE mask 0001, rep 7, `abort` pulsed in the cycle before E2 → exactly 2 toggles, `q_in` bit0 unchanged; `done` high one cycle after E2.
- **RESET then HOLD:** RESET mask 0011 from 1111 → 1100; then HOLD mask 1111, rep 3 → `q_in` stays 1100; `done` one cycle after E4.
- **Checker:** with `JK_BANK_CHECK_EN`, force `q_in` bit2 wrong for one cycle in IDLE → `err`=1 on the next edge and stays high until `rst`. Without the macro, `err` stays 0.
